// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory access arbiter.
package imem_pkg;

  localparam int IMEM_WORDS = 1024;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_F = 1'b0,
    REQ_L = 1'b1
  } req_id_t;

endpackage

// File: rtl/imem_addr_check.sv
// Combinational byte-address check: flags misaligned or out-of-range word addresses.
module imem_addr_check
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_WORDS
) (
  input  logic [31:0] i_addr,
  output logic        o_err
);

  logic w_misaligned;
  logic w_out_of_range;

  assign w_misaligned   = (i_addr[1:0] != 2'b00);
  assign w_out_of_range = ({2'b00, i_addr[31:2]} >= 32'(DEPTH));
  assign o_err          = w_misaligned || w_out_of_range;

endmodule

// File: rtl/imem_access_arbiter.sv
// Arbitrates a single-port synchronous instruction memory between the fetch
// port (F, read-only) and the loader port (L, read/write).
// Optional performance counters are enabled with the IMEM_ARB_PERF_EN macro.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_RUN    | round-robin between F and L
//   ST_DRAIN  | lock requested while a response was in flight; no grants
//   ST_LOCKED | L has exclusive access, F is held off
//
// Response data is steered straight from mem_rdata, which is the memory's own
// output register, so the response lands one cycle after acceptance.
module imem_access_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_WORDS,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req_valid,
  output logic          f_req_ready,
  input  logic [31:0]   f_req_addr,
  output logic          f_rsp_valid,
  output logic [31:0]   f_rsp_data,
  output logic          f_rsp_err,
  input  logic          l_req_valid,
  output logic          l_req_ready,
  input  logic          l_req_we,
  input  logic [31:0]   l_req_addr,
  input  logic [31:0]   l_req_wdata,
  input  logic          l_lock,
  output logic          l_locked,
  output logic          l_rsp_valid,
  output logic [31:0]   l_rsp_data,
  output logic          l_rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  arb_state_t r_state;
  req_id_t    r_last_grant;
  logic       r_l_locked;

  logic r_f_rsp_valid;
  logic r_f_rsp_err;
  logic r_f_rd_ok;
  logic r_l_rsp_valid;
  logic r_l_rsp_err;
  logic r_l_rd_ok;

  logic w_f_err;
  logic w_l_err;
  logic w_run_open;
  logic w_f_ready;
  logic w_l_ready;
  logic w_f_grant;
  logic w_l_grant;
  logic w_outstanding;

  imem_addr_check #(.DEPTH(DEPTH)) u_f_chk (
    .i_addr (f_req_addr),
    .o_err  (w_f_err)
  );

  imem_addr_check #(.DEPTH(DEPTH)) u_l_chk (
    .i_addr (l_req_addr),
    .o_err  (w_l_err)
  );

  // Ready depends only on state, last grant and the other port's valid.
  assign w_run_open = (r_state == ST_RUN) && !l_lock;
  assign w_f_ready  = w_run_open && (!l_req_valid || (r_last_grant == REQ_L));
  assign w_l_ready  = (r_state == ST_LOCKED) ||
                      (w_run_open && (!f_req_valid || (r_last_grant == REQ_F)));
  assign w_f_grant  = f_req_valid && w_f_ready;
  assign w_l_grant  = l_req_valid && w_l_ready;

  assign w_outstanding = r_f_rsp_valid || r_l_rsp_valid;

  // Erroring requests are accepted but never reach the memory.
  assign mem_en    = (w_f_grant && !w_f_err) || (w_l_grant && !w_l_err);
  assign mem_we    = w_l_grant && !w_l_err && l_req_we;
  assign mem_addr  = w_f_grant ? f_req_addr[AW+1:2] :
                     (w_l_grant ? l_req_addr[AW+1:2] : '0);
  assign mem_wdata = mem_we ? l_req_wdata : 32'h0;

  assign f_req_ready = w_f_ready;
  assign l_req_ready = w_l_ready;
  assign l_locked    = r_l_locked;

  assign f_rsp_valid = r_f_rsp_valid;
  assign f_rsp_err   = r_f_rsp_err;
  assign f_rsp_data  = r_f_rd_ok ? mem_rdata : 32'h0;
  assign l_rsp_valid = r_l_rsp_valid;
  assign l_rsp_err   = r_l_rsp_err;
  assign l_rsp_data  = r_l_rd_ok ? mem_rdata : 32'h0;

  // Arbitration FSM: state, round-robin pointer and the registered lock flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_last_grant <= REQ_L;
      r_l_locked   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (l_lock) begin
            if (w_outstanding) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state    <= ST_LOCKED;
              r_l_locked <= 1'b1;
            end
          end else if (w_f_grant) begin
            r_last_grant <= REQ_F;
          end else if (w_l_grant) begin
            r_last_grant <= REQ_L;
          end
        end
        ST_DRAIN: begin
          r_state    <= ST_LOCKED;
          r_l_locked <= 1'b1;
        end
        ST_LOCKED: begin
          // Leaving with last_grant=L lets F win the first contention.
          if (!l_lock) begin
            r_state      <= ST_RUN;
            r_l_locked   <= 1'b0;
            r_last_grant <= REQ_L;
          end else if (w_l_grant) begin
            r_last_grant <= REQ_L;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_l_locked <= 1'b0;
        end
      endcase
    end
  end

  // Response flags for the request granted this cycle; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f_rsp_valid <= 1'b0;
      r_f_rsp_err   <= 1'b0;
      r_f_rd_ok     <= 1'b0;
      r_l_rsp_valid <= 1'b0;
      r_l_rsp_err   <= 1'b0;
      r_l_rd_ok     <= 1'b0;
    end else begin
      r_f_rsp_valid <= w_f_grant;
      r_f_rsp_err   <= w_f_grant && w_f_err;
      r_f_rd_ok     <= w_f_grant && !w_f_err;
      r_l_rsp_valid <= w_l_grant;
      r_l_rsp_err   <= w_l_grant && w_l_err;
      r_l_rd_ok     <= w_l_grant && !w_l_err && !l_req_we;
    end
  end

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  // Free-running wrap-around counters of F grants and F stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= 32'h0;
      r_perf_stall <= 32'h0;
    end else begin
      if (w_f_grant) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (f_req_valid && !w_f_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed self-checking bench for imem_access_arbiter with a behavioural
// single-port synchronous memory. Perf counter checks need IMEM_ARB_PERF_EN.
module tb_imem_access_arbiter;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req_valid;
  logic          f_req_ready;
  logic [31:0]   f_req_addr;
  logic          f_rsp_valid;
  logic [31:0]   f_rsp_data;
  logic          f_rsp_err;
  logic          l_req_valid;
  logic          l_req_ready;
  logic          l_req_we;
  logic [31:0]   l_req_addr;
  logic [31:0]   l_req_wdata;
  logic          l_lock;
  logic          l_locked;
  logic          l_rsp_valid;
  logic [31:0]   l_rsp_data;
  logic          l_rsp_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
`ifdef IMEM_ARB_PERF_EN
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  logic [31:0] mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_access_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .f_req_valid (f_req_valid),
    .f_req_ready (f_req_ready),
    .f_req_addr  (f_req_addr),
    .f_rsp_valid (f_rsp_valid),
    .f_rsp_data  (f_rsp_data),
    .f_rsp_err   (f_rsp_err),
    .l_req_valid (l_req_valid),
    .l_req_ready (l_req_ready),
    .l_req_we    (l_req_we),
    .l_req_addr  (l_req_addr),
    .l_req_wdata (l_req_wdata),
    .l_lock      (l_lock),
    .l_locked    (l_locked),
    .l_rsp_valid (l_rsp_valid),
    .l_rsp_data  (l_rsp_data),
    .l_rsp_err   (l_rsp_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
`ifdef IMEM_ARB_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Single-port memory, one-cycle read latency, read data held between reads.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
    mem[2]    = 32'h0062_E233;
    mem[4]    = 32'h1111_1111;
    mem[1023] = 32'hA5A5_0001;
    mem_rdata   = 32'h0;
    rst         = 1'b1;
    f_req_valid = 1'b0;
    f_req_addr  = 32'h0;
    l_req_valid = 1'b0;
    l_req_we    = 1'b0;
    l_req_addr  = 32'h0;
    l_req_wdata = 32'h0;
    l_lock      = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_f_rsp_valid", f_rsp_valid, 0);
    chk("rst_f_rsp_data",  f_rsp_data,  0);
    chk("rst_f_rsp_err",   f_rsp_err,   0);
    chk("rst_l_rsp_valid", l_rsp_valid, 0);
    chk("rst_l_rsp_data",  l_rsp_data,  0);
    chk("rst_l_rsp_err",   l_rsp_err,   0);
    chk("rst_l_locked",    l_locked,    0);
    chk("rst_mem_en",      mem_en,      0);
    rst = 1'b0;

    // Simple F read of word 2
    tick(); f_req_valid = 1'b1; f_req_addr = 32'h8; #1;
    chk("rd_f_ready",  f_req_ready, 1);
    chk("rd_mem_en",   mem_en,      1);
    chk("rd_mem_we",   mem_we,      0);
    chk("rd_mem_addr", mem_addr,    2);
    tick(); f_req_valid = 1'b0; #1;
    chk("rd_rsp_valid", f_rsp_valid, 1);
    chk("rd_rsp_data",  f_rsp_data,  32'h0062_E233);
    chk("rd_rsp_err",   f_rsp_err,   0);
    chk("rd_l_quiet",   l_rsp_valid, 0);

    // Contention: F was granted last, so L goes first, then alternation
    tick();
    f_req_valid = 1'b1; f_req_addr = 32'h8;
    l_req_valid = 1'b1; l_req_we = 1'b0; l_req_addr = 32'h10; #1;
    chk("rr0_l_ready",  l_req_ready, 1);
    chk("rr0_f_ready",  f_req_ready, 0);
    chk("rr0_mem_addr", mem_addr,    4);
    tick(); #1;
    chk("rr1_l_rsp_valid", l_rsp_valid, 1);
    chk("rr1_l_rsp_data",  l_rsp_data,  32'h1111_1111);
    chk("rr1_f_rsp_valid", f_rsp_valid, 0);
    chk("rr1_f_ready",     f_req_ready, 1);
    chk("rr1_l_ready",     l_req_ready, 0);
    chk("rr1_mem_addr",    mem_addr,    2);
    tick(); #1;
    chk("rr2_f_rsp_valid", f_rsp_valid, 1);
    chk("rr2_f_rsp_data",  f_rsp_data,  32'h0062_E233);
    chk("rr2_l_rsp_valid", l_rsp_valid, 0);
    chk("rr2_l_ready",     l_req_ready, 1);
    tick(); f_req_valid = 1'b0; l_req_valid = 1'b0; #1;
    chk("rr3_l_rsp_valid", l_rsp_valid, 1);

    // Address errors and the last valid word
    tick(); f_req_valid = 1'b1; f_req_addr = 32'h6; #1;
    chk("mis_f_ready", f_req_ready, 1);
    chk("mis_mem_en",  mem_en,      0);
    tick(); f_req_addr = 32'h1000; #1;
    chk("mis_rsp_valid", f_rsp_valid, 1);
    chk("mis_rsp_err",   f_rsp_err,   1);
    chk("mis_rsp_data",  f_rsp_data,  0);
    chk("oor_mem_en",    mem_en,      0);
    tick(); f_req_addr = 32'hFFC; #1;
    chk("oor_rsp_valid", f_rsp_valid, 1);
    chk("oor_rsp_err",   f_rsp_err,   1);
    chk("oor_rsp_data",  f_rsp_data,  0);
    chk("top_mem_en",    mem_en,      1);
    chk("top_mem_addr",  mem_addr,    10'h3FF);
    tick(); f_req_valid = 1'b0; #1;
    chk("top_rsp_err",  f_rsp_err,  0);
    chk("top_rsp_data", f_rsp_data, 32'hA5A5_0001);
    tick(); l_req_valid = 1'b1; l_req_we = 1'b1; l_req_addr = 32'h12; l_req_wdata = 32'h55; #1;
    chk("lmis_mem_en", mem_en, 0);
    tick(); l_req_valid = 1'b0; l_req_we = 1'b0; #1;
    chk("lmis_rsp_valid", l_rsp_valid, 1);
    chk("lmis_rsp_err",   l_rsp_err,   1);
    chk("lmis_rsp_data",  l_rsp_data,  0);

    // Lock with an F read in flight: RUN -> DRAIN -> LOCKED
    tick(); f_req_valid = 1'b1; f_req_addr = 32'h8; #1;
    chk("lk_f_accept", f_req_ready, 1);
    tick(); l_lock = 1'b1; #1;
    chk("lk_f_rsp_valid", f_rsp_valid, 1);
    chk("lk_f_rsp_data",  f_rsp_data,  32'h0062_E233);
    chk("lk_f_ready",     f_req_ready, 0);
    chk("lk_mem_en",      mem_en,      0);
    chk("lk_locked0",     l_locked,    0);
    tick(); #1;
    chk("dr_locked",      l_locked,    0);
    chk("dr_f_rsp_valid", f_rsp_valid, 0);
    chk("dr_f_ready",     f_req_ready, 0);
    chk("dr_l_ready",     l_req_ready, 0);
    tick(); l_req_valid = 1'b1; l_req_we = 1'b1; l_req_addr = 32'h10; l_req_wdata = 32'hDEAD_BEEF; #1;
    chk("lo_locked",    l_locked,    1);
    chk("lo_f_ready",   f_req_ready, 0);
    chk("lo_l_ready",   l_req_ready, 1);
    chk("lo_mem_we",    mem_we,      1);
    chk("lo_mem_addr",  mem_addr,    4);
    chk("lo_mem_wdata", mem_wdata,   32'hDEAD_BEEF);
    tick(); l_req_we = 1'b0; #1;
    chk("wr_ack_valid", l_rsp_valid, 1);
    chk("wr_ack_data",  l_rsp_data,  0);
    chk("wr_ack_err",   l_rsp_err,   0);
    chk("wr_f_ready",   f_req_ready, 0);
    chk("rb_mem_we",    mem_we,      0);
    tick(); l_req_valid = 1'b0; #1;
    chk("rb_l_rsp_valid", l_rsp_valid, 1);
    chk("rb_l_rsp_data",  l_rsp_data,  32'hDEAD_BEEF);
    chk("rb_f_rsp_valid", f_rsp_valid, 0);
    tick(); l_lock = 1'b0; #1;
    chk("ul_still_locked", l_locked,    1);
    chk("ul_f_ready",      f_req_ready, 0);
    tick(); l_req_valid = 1'b1; l_req_we = 1'b0; l_req_addr = 32'h10; #1;
    chk("ul_locked",   l_locked,    0);
    chk("ul_f_wins",   f_req_ready, 1);
    chk("ul_l_waits",  l_req_ready, 0);

    // Reset while an L read response is pending
    tick(); f_req_valid = 1'b0; #1;
    chk("pr_l_ready",     l_req_ready, 1);
    chk("pr_f_rsp_valid", f_rsp_valid, 1);
    tick(); rst = 1'b1; l_req_valid = 1'b0; #1;
    chk("mr_l_rsp_valid", l_rsp_valid, 0);
    chk("mr_l_rsp_data",  l_rsp_data,  0);
    tick(); #1;
    chk("mr2_l_rsp_valid", l_rsp_valid, 0);
    tick(); rst = 1'b0; #1;
    chk("po_l_rsp_valid", l_rsp_valid, 0);
    chk("po_f_rsp_valid", f_rsp_valid, 0);
    chk("po_l_locked",    l_locked,    0);
    chk("po_mem_en",      mem_en,      0);
    tick();
    f_req_valid = 1'b1; f_req_addr = 32'h8;
    l_req_valid = 1'b1; l_req_addr = 32'h10; #1;
    chk("po_f_wins",    f_req_ready, 1);
    chk("po_l_waits",   l_req_ready, 0);
    chk("po_mem_addr",  mem_addr,    2);
    tick(); #1;
    chk("po_l_next",      l_req_ready, 1);
    chk("po_f_rsp_valid2", f_rsp_valid, 1);
    chk("po_f_rsp_data",  f_rsp_data,  32'h0062_E233);
    tick(); f_req_valid = 1'b0; l_req_valid = 1'b0; #1;
    chk("po_l_rsp_data", l_rsp_data, 32'hDEAD_BEEF);

    // Performance counters: 3 F grants, then 2 F stall cycles while LOCKED
    tick(); rst = 1'b1; #1;
    tick(); rst = 1'b0; #1;
    tick(); f_req_valid = 1'b1; f_req_addr = 32'h0; #1;
    tick(); #1;
    tick(); #1;
    tick(); f_req_valid = 1'b0; #1;
    tick(); l_lock = 1'b1; #1;
    chk("pf_no_outstanding", f_rsp_valid, 0);
    tick(); f_req_valid = 1'b1; #1;
    chk("pf_locked",  l_locked,    1);
    chk("pf_f_stall", f_req_ready, 0);
    tick(); #1;
    tick(); f_req_valid = 1'b0; l_lock = 1'b0; #1;
`ifdef IMEM_ARB_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 3);
    chk("perf_stall_cnt", perf_stall_cnt, 2);
`endif
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
